// File: rtl/ps2_keycode_decoder.sv
// PS/2 keyboard front end: conditions the raw bus lines, receives 11-bit
// device-to-host frames and turns make/break byte sequences into key events
// in the clk_audio domain.

// One bus line: 2-flop synchronizer followed by a stability filter.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk_audio,
    input  logic reset,
    input  logic raw,
    output logic filt
);
    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // Synchronize the asynchronous line; presets high like an idle bus.
    always_ff @(posedge clk_audio or posedge reset)
        if (reset) sync <= 2'b11;
        else       sync <= {sync[0], raw};

    // Follow the synchronized value only after FILTER_LEN consecutive samples disagree with it.
    always_ff @(posedge clk_audio or posedge reset)
        if (reset) begin
            cnt  <= '0;
            filt <= 1'b1;
        end else if (sync[1] == filt) begin
            cnt  <= '0;
        end else if (cnt == CW'(FILTER_LEN - 1)) begin
            filt <= sync[1];
            cnt  <= '0;
        end else begin
            cnt  <= cnt + 1'b1;
        end
endmodule

module ps2_keycode_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk_audio,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [8:0] code,
    output logic       pressed,
    output logic       key_valid,
    output logic       frame_error
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic {IDLE, RECV} rx_state_t;

    typedef struct packed {
        logic [8:0] code;
        logic       pressed;
        logic       key_valid;
        logic       frame_error;
    } key_evt_t;

    logic [1:0] raw_lines, filt_lines;
    logic       clk_f, data_f, clk_prev_q, fall;

    rx_state_t  state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;   // bits taken so far in the current frame
    logic [8:0] sh_q, sh_d;             // data bits [7:0] and parity [8] after bit 9
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic       ext_q, ext_d, brk_q, brk_d;
    logic [2:0] skip_q, skip_d;         // bytes still to swallow from a Pause sequence
    key_evt_t   evt_q, evt_d;
    logic       byte_ok;
    logic [7:0] rx_byte;

    assign raw_lines = {ps2_data, ps2_clk};

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt [1:0] (
        .clk_audio (clk_audio),
        .reset     (reset),
        .raw       (raw_lines),
        .filt      (filt_lines)
    );

    assign clk_f  = filt_lines[0];
    assign data_f = filt_lines[1];
    assign fall   = clk_prev_q & ~clk_f;

    assign code        = evt_q.code;
    assign pressed     = evt_q.pressed;
    assign key_valid   = evt_q.key_valid;
    assign frame_error = evt_q.frame_error;

    // State register for the receiver, prefix decoder and output event.
    always_ff @(posedge clk_audio or posedge reset)
        if (reset) begin
            clk_prev_q <= 1'b1;
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            sh_q       <= '0;
            to_cnt_q   <= '0;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            skip_q     <= '0;
            evt_q      <= '0;
        end else begin
            clk_prev_q <= clk_f;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            sh_q       <= sh_d;
            to_cnt_q   <= to_cnt_d;
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            skip_q     <= skip_d;
            evt_q      <= evt_d;
        end

    // Frame reception, timeout and byte decode; a byte accepted on the stop
    // edge is decoded in the same step so the event lands one cycle later.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sh_d      = sh_q;
        to_cnt_d  = to_cnt_q;
        ext_d     = ext_q;
        brk_d     = brk_q;
        skip_d    = skip_q;
        evt_d     = evt_q;
        evt_d.key_valid   = 1'b0;
        evt_d.frame_error = 1'b0;
        byte_ok   = 1'b0;
        rx_byte   = sh_q[7:0];

        case (state_q)
            IDLE: begin
                to_cnt_d = '0;
                // A high start bit is line noise or a lost frame: stay idle to resync.
                if (fall && !data_f) begin
                    state_d   = RECV;
                    bit_cnt_d = 4'd1;
                end
            end
            RECV: begin
                if (fall) begin
                    to_cnt_d = '0;
                    if (bit_cnt_q == 4'd10) begin
                        state_d   = IDLE;
                        bit_cnt_d = '0;
                        if ((^sh_q) && data_f) byte_ok = 1'b1;
                        else                   evt_d.frame_error = 1'b1;
                    end else begin
                        sh_d      = {data_f, sh_q[8:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    to_cnt_d  = '0;
                    ext_d     = 1'b0;
                    brk_d     = 1'b0;
                    skip_d    = '0;
                    evt_d.frame_error = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (byte_ok) begin
            if (skip_q != 3'd0) begin
                skip_d = skip_q - 3'd1;
            end else begin
                case (rx_byte)
                    8'hE1: begin
                        skip_d = 3'd7;
                        ext_d  = 1'b0;
                        brk_d  = 1'b0;
                    end
                    8'hE0: ext_d = 1'b1;
                    8'hF0: brk_d = 1'b1;
                    8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: begin
                        ext_d = 1'b0;
                        brk_d = 1'b0;
                    end
                    default: begin
                        evt_d.code      = {ext_q, rx_byte};
                        evt_d.pressed   = ~brk_q;
                        evt_d.key_valid = 1'b1;
                        ext_d = 1'b0;
                        brk_d = 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ps2_keycode_decoder.sv
// Bench for ps2_keycode_decoder: PS/2 frames are driven at bus level, the
// intended key events go into a queue, and a monitor checks every strobe.
module tb_ps2_keycode_decoder;
    localparam int FILTER_LEN = 8;
    localparam int TO         = 1500;
    localparam int HALF       = 20;

    typedef struct {
        bit         is_err;
        logic [8:0] code;
        logic       pressed;
        int         cyc;      // expected sample cycle, -1 when not timed
    } exp_t;

    logic       clk_audio, reset, ps2_clk, ps2_data;
    logic [8:0] code;
    logic       pressed, key_valid, frame_error;

    bit   clk_run = 1;
    bit   probe = 0, done_req = 0, final_done = 0;
    int   cyc = 0, checks = 0, errors = 0;
    exp_t exp_q[$];
    logic [8:0] m_code = '0;
    logic       m_pressed = 1'b0;

    ps2_keycode_decoder #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TO)) dut (
        .clk_audio   (clk_audio),
        .reset       (reset),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .code        (code),
        .pressed     (pressed),
        .key_valid   (key_valid),
        .frame_error (frame_error)
    );

    initial begin
        clk_audio = 1'b0;
        forever begin
            #5;
            if (clk_run) clk_audio = ~clk_audio;
        end
    end

    always @(posedge clk_audio) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, queue=%0d", exp_q.size());
        $fatal(1, "watchdog");
    end

    // Monitor: every strobe must match the head of the queue; otherwise outputs hold.
    always @(negedge clk_audio or posedge probe) begin
        exp_t e;
        if (probe) begin
            checks++;
            if (code !== 9'h0 || pressed !== 1'b0 || key_valid !== 1'b0 || frame_error !== 1'b0) begin
                errors++;
                $display("FAIL reset_state: code=%h pressed=%b kv=%b fe=%b, required all zero",
                         code, pressed, key_valid, frame_error);
            end
            m_code = '0;
            m_pressed = 1'b0;
        end else if (!reset) begin
            if (key_valid && frame_error) begin
                checks++;
                errors++;
                $display("FAIL both_strobes at cycle %0d", cyc);
            end
            if (key_valid || frame_error) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: kv=%b fe=%b code=%h pressed=%b at cycle %0d",
                             key_valid, frame_error, code, pressed, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_err != frame_error || (!e.is_err && (code !== e.code || pressed !== e.pressed))
                        || (e.cyc >= 0 && cyc != e.cyc)) begin
                        errors++;
                        $display("FAIL event: got fe=%b code=%h pressed=%b cycle=%0d, required fe=%b code=%h pressed=%b cycle=%0d",
                                 frame_error, code, pressed, cyc, e.is_err, e.code, e.pressed, e.cyc);
                    end
                    if (!e.is_err) begin
                        m_code = e.code;
                        m_pressed = e.pressed;
                    end
                end
            end else begin
                checks++;
                if (code !== m_code || pressed !== m_pressed) begin
                    errors++;
                    $display("FAIL hold: code=%h pressed=%b, required code=%h pressed=%b at cycle %0d",
                             code, pressed, m_code, m_pressed, cyc);
                end
            end
            if (done_req && !final_done) begin
                final_done = 1;
                checks++;
                if (exp_q.size() != 0) begin
                    errors++;
                    $display("FAIL missing_events: %0d still expected, required 0", exp_q.size());
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_audio);
    endtask

    // One bus bit: data set while clock high, optional short clock glitch, then the falling edge.
    task automatic drive_bit(input logic b, input int glitch, input bit push, input exp_t e);
        exp_t ee;
        ee = e;
        ps2_data = b;
        if (glitch > 0) begin
            wait_cyc(4);
            ps2_clk = 1'b0;
            wait_cyc(glitch);
            ps2_clk = 1'b1;
            wait_cyc(HALF - 4 - glitch);
        end else begin
            wait_cyc(HALF);
        end
        if (push) begin
            // 2 sync flops + FILTER_LEN samples to see the edge, then one cycle to the strobe.
            ee.cyc = cyc + FILTER_LEN + 3;
            exp_q.push_back(ee);
        end
        ps2_clk = 1'b0;
        wait_cyc(HALF);
        ps2_clk = 1'b1;
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic par;
        par = (~^b) ^ bad_par;
        return {~bad_stop, par, b, 1'b0};
    endfunction

    // kind: 0 no response, 1 key event, 2 frame error.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int kind, input logic [8:0] c, input logic p,
                              input int gbit, input int glen);
        logic [10:0] fr;
        exp_t e;
        fr = mk_frame(b, bad_par, bad_stop);
        e.is_err = (kind == 2);
        e.code = c;
        e.pressed = p;
        e.cyc = -1;
        for (int i = 0; i < 11; i++)
            drive_bit(fr[i], (i == gbit) ? glen : 0, (i == 10) && (kind != 0), e);
        ps2_data = 1'b1;
        wait_cyc(2 * HALF);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 0, 0, 0, '0, 1'b0, -1, 0);
    endtask

    task automatic send_key(input bit ext, input bit brk, input logic [7:0] b, input bit dup);
        if (ext) send_byte(8'hE0);
        if (ext && dup) send_byte(8'hE0);
        if (brk) send_byte(8'hF0);
        send_frame(b, 0, 0, 1, {ext, b}, ~brk, -1, 0);
    endtask

    function automatic logic [7:0] rand_key();
        logic [7:0] b;
        do b = 8'($urandom_range(1, 254));
        while (b == 8'hE0 || b == 8'hE1 || b == 8'hF0 || b == 8'hAA ||
               b == 8'hFA || b == 8'hFE || b == 8'hEE);
        return b;
    endfunction

    task automatic idle_glitch(input int len);
        ps2_data = 1'b0;
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        wait_cyc(len);
        ps2_clk = 1'b1;
        wait_cyc(HALF);
        ps2_data = 1'b1;
        wait_cyc(HALF);
    endtask

    initial begin
        logic [10:0] fr;
        logic [7:0]  ctl [6];
        exp_t        e;
        int          first0;
        ctl = '{8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};

        reset = 1'b1;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        wait_cyc(3);
        probe = 1;
        #1 probe = 0;
        wait_cyc(2);
        reset = 1'b0;
        wait_cyc(20);

        // Plain make, break, extended make/break, repeated prefix, typematic repeat.
        send_key(0, 0, 8'h1C, 0);
        send_key(0, 1, 8'h1C, 0);
        send_key(1, 0, 8'h75, 0);
        send_key(1, 1, 8'h75, 0);
        send_key(1, 0, 8'h75, 1);
        send_key(0, 0, 8'h1C, 0);
        send_key(0, 0, 8'h1C, 0);

        // Parity error, then a good frame.
        send_frame(8'h1C, 1, 0, 2, '0, 1'b0, -1, 0);
        send_key(0, 0, 8'h24, 0);

        // Frame abandoned after 5 bits: one timeout error, then recovery.
        e = '{1, '0, 1'b0, -1};
        exp_q.push_back(e);
        fr = mk_frame(8'h15, 0, 0);
        for (int i = 0; i < 5; i++) drive_bit(fr[i], 0, 0, e);
        ps2_data = 1'b1;
        wait_cyc(TO + 100);
        send_key(0, 0, 8'h15, 0);

        // Pause sequence yields nothing; the following key still decodes.
        send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
        send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
        send_key(0, 0, 8'h1C, 0);

        // Short clock glitches, idle and inside a frame.
        idle_glitch(1);
        idle_glitch(FILTER_LEN - 2);
        send_frame(8'h2B, 0, 0, 1, 9'h02B, 1'b1, 3, 1);
        send_frame(8'h2B, 0, 0, 1, 9'h02B, 1'b1, 10, FILTER_LEN - 2);

        // Reset after bit 4 with the clock stopped, then the rest of the frame.
        fr = mk_frame(8'h1C, 0, 0);
        for (int i = 0; i < 5; i++) drive_bit(fr[i], 0, 0, e);
        reset = 1'b1;
        #1 clk_run = 0;
        #3 probe = 1;
        #1 probe = 0;
        #20 clk_run = 1;
        wait_cyc(3);
        reset = 1'b0;
        first0 = -1;
        for (int i = 5; i < 11; i++) if (first0 < 0 && fr[i] == 1'b0) first0 = i;
        if (first0 >= 0) begin
            e = '{1, '0, 1'b0, -1};
            exp_q.push_back(e);
        end
        for (int i = 5; i < 11; i++) drive_bit(fr[i], 0, 0, e);
        ps2_data = 1'b1;
        wait_cyc(TO + 100);
        send_key(0, 0, 8'h1C, 0);

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            int op;
            op = $urandom_range(0, 9);
            case (op)
                0: send_byte(ctl[$urandom_range(0, 5)]);
                1: begin
                    if ($urandom_range(0, 1) == 0) send_frame(rand_key(), 1, 0, 2, '0, 1'b0, -1, 0);
                    else                           send_frame(rand_key(), 0, 1, 2, '0, 1'b0, -1, 0);
                end
                2: idle_glitch($urandom_range(1, FILTER_LEN - 2));
                default: send_key(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                  rand_key(), 1'($urandom_range(0, 1)));
            endcase
        end

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) wait_cyc(1);
        done_req = 1;
        wait_cyc(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
